// File: rtl/key_manager.sv
// Key-generation sequencer with atomic commit of shadowed n/e/d into the key bank.
// Latency: gen_req -> kg_start 1 cycle; last valid tick -> done 1 cycle; bank updates on the edge after done.
// Backpressure: none; requests outside IDLE, or blocked by key_lock/mode, are dropped rather than queued.
module key_manager #(
  parameter int unsigned TIMEOUT_CYCLES = 2**24,
  parameter logic [1:0]  MODE_KEYGEN    = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        gen_req,
  input  logic        clear,
  input  logic        key_lock,
  input  logic [31:0] n_key_in,
  input  logic [31:0] e_key_in,
  input  logic [31:0] d_key_in,
  input  logic        n_key_valid,
  input  logic        e_key_valid,
  input  logic        d_key_valid,
  output logic        kg_en,
  output logic        kg_start,
  output logic [31:0] n_key,
  output logic [31:0] e_key,
  output logic [31:0] d_key,
  output logic        keys_valid,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_N, WAIT_ED, COMMIT, FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   shadow_n_q, shadow_n_d, shadow_e_q, shadow_e_d, shadow_d_q, shadow_d_d;
  logic [31:0]   n_key_q, n_key_d, e_key_q, e_key_d, d_key_q, d_key_d;
  logic          keys_valid_q, keys_valid_d;
  logic          err_q, err_d;
  logic          kg_start_q, kg_start_d;
  logic          mode_ok;
  logic          timeout;

  assign mode_ok = (mode == MODE_KEYGEN);
  // Counter is cleared in START, so reaching the last count means the full budget has elapsed.
  assign timeout = (cnt_q >= CNT_LAST);

  // Next-state, shadow capture and key-bank update; bank only ever changes in COMMIT or on clear.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_n_d   = shadow_n_q;
    shadow_e_d   = shadow_e_q;
    shadow_d_d   = shadow_d_q;
    n_key_d      = n_key_q;
    e_key_d      = e_key_q;
    d_key_d      = d_key_q;
    keys_valid_d = keys_valid_q;
    err_d        = err_q;
    kg_start_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // clear has priority; a same-cycle gen_req is dropped.
        if (clear && !key_lock) begin
          n_key_d      = '0;
          e_key_d      = '0;
          d_key_d      = '0;
          keys_valid_d = 1'b0;
          err_d        = 1'b0;
        end else if (gen_req && mode_ok && !key_lock) begin
          state_d    = START;
          err_d      = 1'b0;
          kg_start_d = 1'b1;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = mode_ok ? WAIT_N : FAIL;
      end
      WAIT_N: begin
        cnt_d = cnt_q + 1'b1;
        if (!mode_ok) begin
          state_d = FAIL;
        end else if (n_key_valid) begin
          shadow_n_d = n_key_in;
          if (e_key_valid && d_key_valid) begin
            shadow_e_d = e_key_in;
            shadow_d_d = d_key_in;
            state_d    = COMMIT;
          end else begin
            state_d = WAIT_ED;
          end
        end else if (timeout) begin
          state_d = FAIL;
        end
      end
      WAIT_ED: begin
        cnt_d = cnt_q + 1'b1;
        if (!mode_ok) begin
          state_d = FAIL;
        end else if (e_key_valid && d_key_valid) begin
          shadow_e_d = e_key_in;
          shadow_d_d = d_key_in;
          state_d    = COMMIT;
        end else if (e_key_valid ^ d_key_valid) begin
          state_d = FAIL;
        end else if (timeout) begin
          state_d = FAIL;
        end else if (n_key_valid) begin
          shadow_n_d = n_key_in;
        end
      end
      COMMIT: begin
        n_key_d      = shadow_n_q;
        e_key_d      = shadow_e_q;
        d_key_d      = shadow_d_q;
        keys_valid_d = 1'b1;
        state_d      = IDLE;
      end
      FAIL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // err rises as FAIL is entered, so it is visible while busy is still high.
    if (state_d == FAIL) begin
      err_d = 1'b1;
    end
  end

  // State, shadow and bank registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shadow_n_q   <= '0;
      shadow_e_q   <= '0;
      shadow_d_q   <= '0;
      n_key_q      <= '0;
      e_key_q      <= '0;
      d_key_q      <= '0;
      keys_valid_q <= 1'b0;
      err_q        <= 1'b0;
      kg_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_n_q   <= shadow_n_d;
      shadow_e_q   <= shadow_e_d;
      shadow_d_q   <= shadow_d_d;
      n_key_q      <= n_key_d;
      e_key_q      <= e_key_d;
      d_key_q      <= d_key_d;
      keys_valid_q <= keys_valid_d;
      err_q        <= err_d;
      kg_start_q   <= kg_start_d;
    end
  end

  assign kg_en      = mode_ok;
  assign kg_start   = kg_start_q;
  assign n_key      = n_key_q;
  assign e_key      = e_key_q;
  assign d_key      = d_key_q;
  assign keys_valid = keys_valid_q;
  assign err        = err_q;
  assign done       = (state_q == COMMIT);
  assign busy       = (state_q != IDLE);

endmodule
